// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the baud timing helper
// used by both the receive and transmit paths.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Whole system clocks per bit; the fractional part is dropped.
  function automatic int clksPerBit(input int freqMhz, input int bauds);
    return (freqMhz * 1000000) / bauds;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doWrite;
  logic             doRead;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign doRead  = pop_i && !empty_o;
  assign doWrite = push_i && (!full_o || doRead);

  assign wrPtr_d = wrPtr_q + (AW+1)'(doWrite);
  assign rdPtr_d = rdPtr_q + (AW+1)'(doRead);

  assign level_o = wrPtr_q - rdPtr_q;
  assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling FSM and a
// receive FIFO drained through a valid/ready port.
module uart_receiver #(
  parameter int FREQ_MHZ   = 12,
  parameter int BAUDS      = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n_i,
  input  logic                          rx_i,
  output logic [7:0]                    data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  import uart_pkg::*;

  localparam int CLKS_PER_BIT = clksPerBit(FREQ_MHZ, BAUDS);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);

  logic                 rxMeta_q;
  logic                 rxSync_q;
  rx_state_t            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bitIdx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frameErr_q;
  logic                 overrun_q;

  logic halfDone;
  logic bitDone;
  logic push;
  logic pop;
  logic fifoFull;
  logic fifoEmpty;

  // Both flops idle high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx_i;
      rxSync_q <= rxMeta_q;
    end
  end

  assign halfDone = (cnt_q == CNT_W'(HALF - 1));
  assign bitDone  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
    end else begin
      frameErr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxSync_q) begin
            state_q <= START;
          end
        end
        START: begin
          if (halfDone) begin
            cnt_q    <= '0;
            bitIdx_q <= '0;
            state_q  <= rxSync_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bitDone) begin
            cnt_q             <= '0;
            shift_q[bitIdx_q] <= rxSync_q;
            bitIdx_q          <= bitIdx_q + BIT_W'(1);
            if (bitIdx_q == BIT_W'(DATA_BITS - 1)) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bitDone) begin
            cnt_q <= '0;
            if (rxSync_q) begin
              state_q <= IDLE;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          cnt_q <= '0;
          if (rxSync_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The byte is written on the same edge that samples a good stop bit.
  assign push = (state_q == STOP) && bitDone && rxSync_q;
  assign pop  = valid_o && ready_i;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && fifoFull && !pop;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .wdata_i   (shift_q),
    .pop_i     (pop),
    .rdata_o   (data_o),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty),
    .level_o   (level_o)
  );

  assign valid_o     = !fifoEmpty;
  assign frame_err_o = frameErr_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames are driven bit by bit and a queue
// model of the receive path is compared with the DUT on every falling edge.
module tb_uart_receiver;

  localparam int FREQ_MHZ = 12;
  localparam int BAUDS    = 115200;
  localparam int DEPTH    = 16;
  localparam int CPB      = (FREQ_MHZ * 1000000) / BAUDS;
  localparam int HALF     = CPB / 2;
  localparam int LAT      = 2 + HALF + 9 * CPB + 1;

  logic       clk;
  logic       reset_n_i;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic [4:0] level_o;

  typedef struct {
    int         cycle;
    logic [7:0] data;
    bit         stopOk;
  } frameEvt_t;

  int         cyc;
  int         total;
  int         bad;
  int         errPulses;
  int         ovrPulses;
  bit         popPending;
  bit         expErr;
  bit         expOvr;
  frameEvt_t  ev;
  frameEvt_t  evtQ[$];
  logic [7:0] modelQ[$];
  logic [7:0] drained[$];

  uart_receiver #(
    .FREQ_MHZ   (FREQ_MHZ),
    .BAUDS      (BAUDS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n_i   (reset_n_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .level_o     (level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Drives one 8N1 frame starting now; the model learns when its outcome is due.
  task automatic applyStimulus(input logic [7:0] b, input bit stopOk, input bit pulseReady);
    int        p;
    logic [9:0] bits;
    frameEvt_t e;
    p = cyc;
    bits = {stopOk, b, 1'b0};
    e.cycle = p + LAT;
    e.data = b;
    e.stopOk = stopOk;
    evtQ.push_back(e);
    for (int t = 0; t < 10 * CPB; t++) begin
      rx_i = bits[t / CPB];
      if (pulseReady && t == LAT - 1) ready_i = 1'b1;
      if (pulseReady && t == LAT) ready_i = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    expErr = 1'b0;
    expOvr = 1'b0;
    if (!reset_n_i) begin
      modelQ.delete();
      evtQ.delete();
      popPending = 1'b0;
      checkOutput("rst valid_o", 32'(valid_o), 0);
      checkOutput("rst data_o", 32'(data_o), 0);
      checkOutput("rst level_o", 32'(level_o), 0);
      checkOutput("rst frame_err_o", 32'(frame_err_o), 0);
      checkOutput("rst overrun_o", 32'(overrun_o), 0);
    end else begin
      if (popPending) void'(modelQ.pop_front());
      if (evtQ.size() > 0 && evtQ[0].cycle == cyc) begin
        ev = evtQ.pop_front();
        if (!ev.stopOk) expErr = 1'b1;
        else if (modelQ.size() < DEPTH) modelQ.push_back(ev.data);
        else expOvr = 1'b1;
      end
      checkOutput("valid_o", 32'(valid_o), 32'(modelQ.size() != 0));
      checkOutput("level_o", 32'(level_o), 32'(modelQ.size()));
      if (modelQ.size() != 0) checkOutput("data_o", 32'(data_o), 32'(modelQ[0]));
      checkOutput("frame_err_o", 32'(frame_err_o), 32'(expErr));
      checkOutput("overrun_o", 32'(overrun_o), 32'(expOvr));
      popPending = (modelQ.size() != 0) && ready_i;
    end
    if (frame_err_o) errPulses++;
    if (overrun_o) ovrPulses++;
    if (valid_o && ready_i && reset_n_i) drained.push_back(data_o);
  end

  initial begin
    #900000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int p, e0, o0;
    total = 0;
    bad = 0;
    errPulses = 0;
    ovrPulses = 0;
    popPending = 1'b0;
    reset_n_i = 1'b0;
    rx_i = 1'b1;
    ready_i = 1'b1;
    idle(3);
    checkOutput("reset valid_o", 32'(valid_o), 0);
    checkOutput("reset level_o", 32'(level_o), 0);
    checkOutput("reset data_o", 32'(data_o), 0);
    reset_n_i = 1'b1;
    idle(10);

    // Single 0x55: valid_o first seen 991 clocks after the start bit.
    p = cyc;
    e0 = errPulses;
    o0 = ovrPulses;
    fork
      applyStimulus(8'h55, 1'b1, 1'b0);
      begin
        while (cyc < p + 990) @(negedge clk);
        checkOutput("latency pre", 32'(valid_o), 0);
        @(negedge clk);
        checkOutput("latency valid", 32'(valid_o), 1);
        checkOutput("latency data", 32'(data_o), 32'h55);
        @(negedge clk);
        checkOutput("single pulse valid", 32'(valid_o), 0);
        checkOutput("single level", 32'(level_o), 0);
      end
    join
    idle(20);
    checkOutput("single no err", 32'(errPulses - e0), 0);
    checkOutput("single no ovr", 32'(ovrPulses - o0), 0);

    // Start-bit glitch followed by 0xA7.
    drained.delete();
    rx_i = 1'b0;
    idle(20);
    rx_i = 1'b1;
    idle(200);
    checkOutput("glitch valid", 32'(valid_o), 0);
    checkOutput("glitch err", 32'(errPulses - e0), 0);
    applyStimulus(8'hA7, 1'b1, 1'b0);
    idle(20);
    checkOutput("glitch drain count", 32'(drained.size()), 1);
    if (drained.size() > 0) checkOutput("glitch drain byte", 32'(drained[0]), 32'hA7);

    // Framing error with a long break, then 0x3C.
    drained.delete();
    e0 = errPulses;
    applyStimulus(8'hA3, 1'b0, 1'b0);
    idle(500);
    rx_i = 1'b1;
    idle(100);
    checkOutput("ferr pulses", 32'(errPulses - e0), 1);
    checkOutput("ferr level", 32'(level_o), 0);
    checkOutput("ferr no push", 32'(drained.size()), 0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    idle(20);
    checkOutput("ferr next count", 32'(drained.size()), 1);
    if (drained.size() > 0) checkOutput("ferr next byte", 32'(drained[0]), 32'h3C);

    // Overrun: 17 back-to-back bytes with the consumer stalled.
    ready_i = 1'b0;
    o0 = ovrPulses;
    for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b1, 1'b0);
    idle(5);
    checkOutput("ovr level", 32'(level_o), 16);
    checkOutput("ovr pulses", 32'(ovrPulses - o0), 1);
    drained.delete();
    ready_i = 1'b1;
    idle(30);
    checkOutput("ovr drain count", 32'(drained.size()), 16);
    for (int i = 0; i < 16; i++)
      if (drained.size() > i) checkOutput("ovr drain byte", 32'(drained[i]), 32'(i));
    checkOutput("ovr drained level", 32'(level_o), 0);

    // Full FIFO with a pop on the stop-sample edge of the 17th byte.
    ready_i = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h20 + i), 1'b1, 1'b0);
    checkOutput("full level", 32'(level_o), 16);
    o0 = ovrPulses;
    drained.delete();
    applyStimulus(8'h30, 1'b1, 1'b1);
    idle(5);
    checkOutput("full+pop level", 32'(level_o), 16);
    checkOutput("full+pop no ovr", 32'(ovrPulses - o0), 0);
    checkOutput("full+pop popped", 32'(drained.size()), 1);
    drained.delete();
    ready_i = 1'b1;
    idle(30);
    checkOutput("full+pop drain count", 32'(drained.size()), 16);
    if (drained.size() == 16) begin
      checkOutput("full+pop first", 32'(drained[0]), 32'h21);
      checkOutput("full+pop last", 32'(drained[15]), 32'h30);
    end

    // Reset during bit 4 of 0xFF with a byte already buffered.
    ready_i = 1'b0;
    applyStimulus(8'h5A, 1'b1, 1'b0);
    idle(10);
    checkOutput("pre-reset level", 32'(level_o), 1);
    rx_i = 1'b0;
    idle(CPB);
    rx_i = 1'b1;
    idle(4 * CPB + HALF);
    reset_n_i = 1'b0;
    idle(5);
    checkOutput("midreset valid_o", 32'(valid_o), 0);
    checkOutput("midreset level_o", 32'(level_o), 0);
    checkOutput("midreset data_o", 32'(data_o), 0);
    reset_n_i = 1'b1;
    idle(6 * CPB);
    drained.delete();
    ready_i = 1'b1;
    applyStimulus(8'h81, 1'b1, 1'b0);
    idle(20);
    checkOutput("post-reset count", 32'(drained.size()), 1);
    if (drained.size() > 0) checkOutput("post-reset byte", 32'(drained[0]), 32'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
